ram_sp_arbiter: RTL

Two-master arbiter sharing one synchronous RAM port (active-low chip/write enables, byte-lane write, 1-cycle registered read) between the CPU data bus and the DMA engine. It sits between both masters and port B of the data-memory dual-port RAM. Per-master ready/data-valid handshakes are provided. Arbitration is round-robin, or fixed DMA priority with a CPU anti-starvation counter. A saturating contention counter is exposed for debug.

---
 rtl/ram_sp_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_arbiter
// Brief    : Shares one synchronous single-port RAM between the CPU and DMA
//            masters, using round-robin or DMA-priority arbitration with an
//            anti-starvation guard for the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_arbiter #(
    parameter int ADDR_MSB     = 6,
    parameter int MEM_SIZE     = 256,
    parameter int DMA_PRIORITY = 0,
    parameter int STARVE_MAX   = 3
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [ADDR_MSB:0] cpu_addr,
    input  logic              cpu_en,
    input  logic [1:0]        cpu_wen,
    input  logic [15:0]       cpu_din,
    output logic              cpu_ready,
    output logic [15:0]       cpu_dout,
    output logic              cpu_dvalid,
    input  logic [ADDR_MSB:0] dma_addr,
    input  logic              dma_en,
    input  logic [1:0]        dma_wen,
    input  logic [15:0]       dma_din,
    output logic              dma_ready,
    output logic [15:0]       dma_dout,
    output logic              dma_dvalid,
    output logic [ADDR_MSB:0] ram_addr,
    output logic              ram_cen,
    output logic [1:0]        ram_wen,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout,
    output logic [7:0]        dbg_conflict_cnt
);

    localparam logic [31:0] MEM_WORDS  = 32'(MEM_SIZE / 2);
    localparam int          STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } master_t;

    master_t             last_grant;
    master_t             rd_owner;
    logic                rd_valid;
    logic                rd_oor;
    logic [STARVE_W-1:0] starve_cnt;
    logic [7:0]          conflict_cnt;

    logic                grant_cpu;
    logic                grant_dma;
    logic                granted;
    logic                both_req;
    logic [ADDR_MSB:0]   sel_addr;
    logic [1:0]          sel_wen;
    logic [15:0]         sel_din;
    logic                sel_oor;

    assign both_req = cpu_en & dma_en;
    assign granted  = grant_cpu | grant_dma;

    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (!puc_rst) begin
            if (both_req) begin
                if (DMA_PRIORITY != 0) begin
                    grant_cpu = (starve_cnt == STARVE_LIM);
                end else begin
                    grant_cpu = (last_grant == GNT_DMA);
                end
                grant_dma = ~grant_cpu;
            end else begin
                grant_cpu = cpu_en;
                grant_dma = dma_en;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_wen  = 2'b11;
        sel_din  = 16'h0000;
        sel_oor  = 1'b0;
        if (grant_cpu) begin
            sel_addr = cpu_addr;
            sel_wen  = cpu_wen;
            sel_din  = cpu_din;
            sel_oor  = (32'(cpu_addr) >= MEM_WORDS);
        end else if (grant_dma) begin
            sel_addr = dma_addr;
            sel_wen  = dma_wen;
            sel_din  = dma_din;
            sel_oor  = (32'(dma_addr) >= MEM_WORDS);
        end
    end

    // Out-of-range accesses are acknowledged but never reach the RAM.
    assign ram_addr = sel_addr;
    assign ram_wen  = sel_wen;
    assign ram_din  = sel_din;
    assign ram_cen  = ~(granted & ~sel_oor);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            last_grant   <= GNT_DMA;
            rd_valid     <= 1'b0;
            rd_owner     <= GNT_CPU;
            rd_oor       <= 1'b0;
            starve_cnt   <= '0;
            conflict_cnt <= 8'h00;
        end else begin
            if (grant_cpu) begin
                last_grant <= GNT_CPU;
            end else if (grant_dma) begin
                last_grant <= GNT_DMA;
            end

            rd_valid <= granted & (sel_wen == 2'b11);
            rd_owner <= grant_dma ? GNT_DMA : GNT_CPU;
            rd_oor   <= sel_oor;

            if (DMA_PRIORITY == 0 || grant_cpu) begin
                starve_cnt <= '0;
            end else if (cpu_en && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end

            if (both_req && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'h01;
            end
        end
    end

    assign cpu_ready  = grant_cpu;
    assign dma_ready  = grant_dma;
    assign cpu_dvalid = rd_valid & (rd_owner == GNT_CPU);
    assign dma_dvalid = rd_valid & (rd_owner == GNT_DMA);
    assign cpu_dout   = (cpu_dvalid && !rd_oor) ? ram_dout : 16'h0000;
    assign dma_dout   = (dma_dvalid && !rd_oor) ? ram_dout : 16'h0000;

    assign dbg_conflict_cnt = conflict_cnt;

endmodule
`default_nettype wire
